spi_host_master: RTL and testbench

SPI_HOST_MASTER -- requirements
Module: spi_host_master

---
 rtl/spi_host_master.sv | 160 ++++++++++++++++
 tb/tb_spi_host_master.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_host_master.sv
// spi_host_master: SPI mode-0 host issuing an address frame then a data frame per transaction.
// Rev 1.0 - initial release.
`default_nettype none

`ifndef ACK
`define ACK 8'hA5
`endif

module spi_host_master #(
    parameter int          CLK_DIV    = 4,
    parameter int          GAP_CYCLES = 8,
    parameter logic [7:0]  ACK_CODE   = `ACK
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_wr,
    input  logic [6:0] i_addr,
    input  logic [7:0] i_wdata,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_rdata,
    output logic       o_ack_err,
    output logic       o_sclk,
    output logic       o_mosi,
    output logic       o_cs_n,
    input  logic       i_miso
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CS_SETUP   = 3'd1,
        SHIFT_ADDR = 3'd2,
        GAP        = 3'd3,
        SHIFT_DATA = 3'd4,
        CS_HOLD    = 3'd5,
        DONE       = 3'd6
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t      state;
    logic [7:0]  presc;
    logic [2:0]  bit_cnt;
    logic [7:0]  tx_sr;
    logic [7:0]  data_frame;
    logic        wr_lat;
    logic [7:0]  rx_sr;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state      <= IDLE;
            presc      <= 8'd0;
            bit_cnt    <= 3'd0;
            tx_sr      <= 8'd0;
            data_frame <= 8'd0;
            wr_lat     <= 1'b0;
            rx_sr      <= 8'd0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_rdata    <= 8'd0;
            o_ack_err  <= 1'b0;
            o_sclk     <= 1'b0;
            o_mosi     <= 1'b0;
            o_cs_n     <= 1'b1;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    o_sclk  <= 1'b0;
                    presc   <= 8'd0;
                    bit_cnt <= 3'd0;
                    if (i_start) begin
                        state      <= CS_SETUP;
                        wr_lat     <= i_wr;
                        tx_sr      <= {i_wr, i_addr};
                        data_frame <= i_wr ? i_wdata : 8'h00;
                        o_mosi     <= i_wr;
                        o_cs_n     <= 1'b0;
                        o_busy     <= 1'b1;
                    end else begin
                        o_cs_n <= 1'b1;
                        o_mosi <= 1'b0;
                    end
                end
                CS_SETUP: begin
                    if (presc == DIV_LAST) begin
                        state   <= SHIFT_ADDR;
                        presc   <= 8'd0;
                        bit_cnt <= 3'd0;
                    end else begin
                        presc <= presc + 8'd1;
                    end
                end
                SHIFT_ADDR, SHIFT_DATA: begin
                    if (presc == DIV_LAST) begin
                        presc <= 8'd0;
                        if (!o_sclk) begin
                            o_sclk <= 1'b1;
                            // Address-frame MISO is don't-care from the slave.
                            if (state == SHIFT_DATA)
                                rx_sr <= {rx_sr[6:0], i_miso};
                        end else begin
                            o_sclk <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= 3'd0;
                                if (state == SHIFT_ADDR) begin
                                    state  <= GAP;
                                    tx_sr  <= data_frame;
                                    o_mosi <= data_frame[7];
                                end else begin
                                    state  <= CS_HOLD;
                                    o_mosi <= 1'b0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                o_mosi  <= tx_sr[6];
                                tx_sr   <= {tx_sr[6:0], 1'b0};
                            end
                        end
                    end else begin
                        presc <= presc + 8'd1;
                    end
                end
                GAP: begin
                    if (presc == GAP_LAST) begin
                        state   <= SHIFT_DATA;
                        presc   <= 8'd0;
                        bit_cnt <= 3'd0;
                    end else begin
                        presc <= presc + 8'd1;
                    end
                end
                CS_HOLD: begin
                    if (presc == DIV_LAST) begin
                        state     <= DONE;
                        presc     <= 8'd0;
                        o_cs_n    <= 1'b1;
                        o_done    <= 1'b1;
                        o_rdata   <= rx_sr;
                        o_ack_err <= wr_lat && (rx_sr != ACK_CODE);
                    end else begin
                        presc <= presc + 8'd1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                    // A held start pre-asserts CS so back-to-back frames see a single-cycle CS gap.
                    o_cs_n <= ~i_start;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_host_master.sv
// tb_spi_host_master: directed self-checking bench with a behavioural SPI mode-0 slave.
// Rev 1.0 - initial release.
`default_nettype none

module tb_spi_host_master;

    localparam logic [7:0] ACK_VAL = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       wr;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       ack_err;
    logic       sclk;
    logic       mosi;
    logic       cs_n;
    logic       miso;

    int checks   = 0;
    int failures = 0;

    spi_host_master #(
        .CLK_DIV   (4),
        .GAP_CYCLES(8),
        .ACK_CODE  (ACK_VAL)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_wr     (wr),
        .i_addr   (addr),
        .i_wdata  (wdata),
        .o_busy   (busy),
        .o_done   (done),
        .o_rdata  (rdata),
        .o_ack_err(ack_err),
        .o_sclk   (sclk),
        .o_mosi   (mosi),
        .o_cs_n   (cs_n),
        .i_miso   (miso)
    );

    always #5 clk = ~clk;

    // Slave: {address-frame reply, data-frame reply}, next bit presented on each SCLK fall.
    logic [15:0] resp     = 16'h0000;
    logic [4:0]  fall_cnt = 5'd0;
    logic [15:0] mosi_sr  = 16'h0000;

    always @(negedge sclk or posedge cs_n) begin
        if (cs_n) fall_cnt <= 5'd0;
        else      fall_cnt <= fall_cnt + 5'd1;
    end

    assign miso = (fall_cnt < 5'd16) ? resp[4'(5'd15 - fall_cnt)] : 1'b0;

    always @(posedge sclk) mosi_sr <= {mosi_sr[14:0], mosi};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // cyc = number of edges since and including the accept edge when done is seen.
    task automatic run_txn(input logic w, input logic [6:0] a, input logic [7:0] d, output int cyc);
        wr    = w;
        addr  = a;
        wdata = d;
        start = 1'b1;
        tick();
        cyc   = 1;
        start = 1'b0;
        check("busy_at_accept", 32'(busy), 32'd1);
        check("cs_low_at_accept", 32'(cs_n), 32'd0);
        wr    = ~w;
        addr  = ~a;
        wdata = ~d;
        while (!done && cyc < 400) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int ndone;
        int hi;

        rst   = 1'b0;
        start = 1'b0;
        wr    = 1'b0;
        addr  = 7'h00;
        wdata = 8'h00;
        repeat (3) tick();
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdata", 32'(rdata), 32'h00);
        check("rst_ack_err", 32'(ack_err), 32'd0);
        rst = 1'b1;
        tick();

        // Write 0x12 <- 0x5A, slave acknowledges.
        resp = {8'h3C, ACK_VAL};
        run_txn(1'b1, 7'h12, 8'h5A, cyc);
        check("wr_done_cycle", cyc, 32'd145);
        check("wr_mosi_frames", 32'(mosi_sr), 32'h925A);
        check("wr_ack_err", 32'(ack_err), 32'd0);
        check("wr_rdata", 32'(rdata), 32'(ACK_VAL));
        check("wr_cs_high_at_done", 32'(cs_n), 32'd1);
        tick();
        check("wr_done_one_cycle", 32'(done), 32'd0);
        check("wr_busy_after", 32'(busy), 32'd0);

        // Read 0x05, slave returns 0xC3 in the data frame.
        resp = {8'hFF, 8'hC3};
        run_txn(1'b0, 7'h05, 8'h77, cyc);
        check("rd_done_cycle", cyc, 32'd145);
        check("rd_mosi_frames", 32'(mosi_sr), 32'h0500);
        check("rd_rdata", 32'(rdata), 32'hC3);
        check("rd_ack_err", 32'(ack_err), 32'd0);
        tick();

        // Write with no acknowledge.
        resp = 16'h0000;
        run_txn(1'b1, 7'h40, 8'hE1, cyc);
        check("nak_done_cycle", cyc, 32'd145);
        check("nak_ack_err", 32'(ack_err), 32'd1);
        check("nak_rdata", 32'(rdata), 32'h00);
        check("nak_mosi_frames", 32'(mosi_sr), 32'hC0E1);
        tick();

        // Start pulsed mid-transaction is not queued.
        resp  = {8'h00, ACK_VAL};
        wr    = 1'b1;
        addr  = 7'h33;
        wdata = 8'h11;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (18) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (done) ndone++;
        end
        check("busy_start_done_count", ndone, 32'd1);
        check("busy_start_idle_after", 32'(busy), 32'd0);
        check("busy_start_mosi", 32'(mosi_sr), 32'hB311);

        // Reset at first SCLK rise of the data frame.
        resp  = {8'h00, ACK_VAL};
        wr    = 1'b1;
        addr  = 7'h12;
        wdata = 8'h5A;
        start = 1'b1;
        tick();
        cyc   = 1;
        start = 1'b0;
        while (cyc < 80) begin
            tick();
            cyc++;
        end
        check("abort_pre_cs_low", 32'(cs_n), 32'd0);
        rst = 1'b0;
        tick();
        check("abort_cs_n", 32'(cs_n), 32'd1);
        check("abort_sclk", 32'(sclk), 32'd0);
        rst = 1'b1;
        ndone = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 32'd0);
        resp = {8'h00, ACK_VAL};
        run_txn(1'b1, 7'h2A, 8'hC7, cyc);
        check("post_abort_done_cycle", cyc, 32'd145);
        check("post_abort_mosi", 32'(mosi_sr), 32'hAAC7);
        check("post_abort_ack_err", 32'(ack_err), 32'd0);
        tick();

        // Start held high: back-to-back transactions.
        resp  = {8'h00, ACK_VAL};
        wr    = 1'b1;
        addr  = 7'h01;
        wdata = 8'h02;
        start = 1'b1;
        tick();
        cyc = 1;
        while (!done && cyc < 400) begin
            tick();
            cyc++;
        end
        check("b2b_first_done_cycle", cyc, 32'd145);
        hi = 0;
        while (cs_n && hi < 10) begin
            hi++;
            tick();
        end
        check("b2b_cs_gap", hi, 32'd1);
        cyc = 0;
        while (!done && cyc < 400) begin
            tick();
            cyc++;
        end
        check("b2b_second_done_seen", 32'(done), 32'd1);
        check("b2b_second_mosi", 32'(mosi_sr), 32'h8102);
        start = 1'b0;
        repeat (3) tick();
        check("b2b_busy_after", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
